// File: rtl/sd_pkg.sv
// Shared SD-over-SPI constants, state and error encodings for the block writer
// and the SD controller.
package sd_pkg;
   localparam logic [5:0] CMD24_IDX    = 6'd24;
   localparam logic [7:0] CMD24_BYTE   = {2'b01, CMD24_IDX};
   localparam logic [7:0] START_TOKEN  = 8'hFE;
   localparam logic [7:0] FILL_BYTE    = 8'hFF;
   localparam logic [7:0] CMD_CRC_BYTE = 8'hFF;
   localparam logic [7:0] DRESP_MASK   = 8'h1F;
   localparam logic [7:0] DRESP_ACCEPT = 8'h05;
   localparam int BLOCK_BYTES  = 512;
   localparam int CMD_BYTES    = 6;
   localparam int R1_MAX_BYTES = 8;
   localparam int CRC_BYTES    = 2;

   typedef enum logic [3:0] {
      ST_IDLE, ST_CMD, ST_R1, ST_GAP, ST_TOKEN,
      ST_DATA, ST_CRC, ST_DRESP, ST_BUSYW, ST_DONE
   } sd_state_e;

   typedef enum logic [2:0] {
      ERR_OK           = 3'd0,
      ERR_R1_TIMEOUT   = 3'd1,
      ERR_R1_NONZERO   = 3'd2,
      ERR_DATA_REJECT  = 3'd3,
      ERR_BUSY_TIMEOUT = 3'd4
   } sd_err_e;

   // Byte idx of the six-byte CMD24 frame: index, 32-bit argument MSB-first, dummy CRC.
   function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] arg);
      case (idx)
         3'd0:    cmd_byte = CMD24_BYTE;
         3'd1:    cmd_byte = arg[31:24];
         3'd2:    cmd_byte = arg[23:16];
         3'd3:    cmd_byte = arg[15:8];
         3'd4:    cmd_byte = arg[7:0];
         default: cmd_byte = CMD_CRC_BYTE;
      endcase
   endfunction
endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: SCLK divider plus one 8-bit full-duplex transfer per load strobe.
module spi_byte_engine #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       active,
   output logic       done,
   output logic [7:0] rx_byte
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx_sh;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active  <= 1'b0;
         sclk    <= 1'b0;
         done    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sh   <= 8'hFF;
         rx_byte <= '0;
      end else begin
         done <= 1'b0;
         if (!active) begin
            if (load) begin
               active  <= 1'b1;
               tx_sh   <= tx_byte;
               div_cnt <= '0;
               bit_cnt <= '0;
            end
         end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DW'(1);
         end else begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
               rx_byte <= {rx_byte[6:0], miso};
            end else begin
               // MOSI advances only after a falling edge; the final fall ends the byte.
               tx_sh   <= {tx_sh[6:0], 1'b1};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  active <= 1'b0;
                  done   <= 1'b1;
               end
            end
         end
      end
   end

   assign mosi = active ? tx_sh[7] : 1'b1;
endmodule

// File: rtl/sd_block_writer.sv
// Writes one 512-byte block to an SD card over SPI with CMD24, streaming the payload
// from a valid/ready byte interface and reporting the outcome in err_code.
module sd_block_writer import sd_pkg::*; #(
   parameter int CLK_DIV      = 2,
   parameter int BUSY_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_write,
   input  logic [31:0] write_addr,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        spi_cs,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_sclk,
   output logic        busy,
   output logic        write_done,
   output logic        write_error,
   output logic [2:0]  err_code
);
   localparam int BW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

   sd_state_e   state, state_nxt;
   logic [9:0]  byte_cnt;
   logic [BW-1:0] busy_cnt;
   logic [31:0] addr_q;
   logic [2:0]  err_q;
   logic        eng_load, eng_active, eng_done;
   logic [7:0]  eng_tx, eng_rx;
   logic        byte_due, busy_last, dresp_ok;

   spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_eng (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (eng_load),
      .tx_byte (eng_tx),
      .miso    (spi_miso),
      .sclk    (spi_sclk),
      .mosi    (spi_mosi),
      .active  (eng_active),
      .done    (eng_done),
      .rx_byte (eng_rx)
   );

   assign busy_last = (busy_cnt == BW'(BUSY_TIMEOUT - 1));
   assign dresp_ok  = ((eng_rx & DRESP_MASK) == DRESP_ACCEPT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_write) state_nxt = ST_CMD;
         ST_CMD:   if (eng_done && byte_cnt == 10'(CMD_BYTES - 1)) state_nxt = ST_R1;
         ST_R1:
            if (eng_done) begin
               if (!eng_rx[7])
                  state_nxt = (eng_rx == 8'h00) ? ST_GAP : ST_DONE;
               else if (byte_cnt == 10'(R1_MAX_BYTES - 1))
                  state_nxt = ST_DONE;
            end
         ST_GAP:   if (eng_done) state_nxt = ST_TOKEN;
         ST_TOKEN: if (eng_done) state_nxt = ST_DATA;
         ST_DATA:  if (eng_done && byte_cnt == 10'(BLOCK_BYTES - 1)) state_nxt = ST_CRC;
         ST_CRC:   if (eng_done && byte_cnt == 10'(CRC_BYTES - 1)) state_nxt = ST_DRESP;
         ST_DRESP: if (eng_done) state_nxt = dresp_ok ? ST_BUSYW : ST_DONE;
         ST_BUSYW: if (eng_done && (eng_rx != 8'h00 || busy_last)) state_nxt = ST_DONE;
         ST_DONE:  if (eng_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // A new byte is issued only once the engine is idle and the previous done has been consumed.
   always_comb begin
      byte_due   = !eng_active && !eng_done && (state != ST_IDLE);
      eng_tx     = FILL_BYTE;
      data_ready = 1'b0;
      case (state)
         ST_CMD:   eng_tx = cmd_byte(byte_cnt[2:0], addr_q);
         ST_TOKEN: eng_tx = START_TOKEN;
         ST_DATA: begin
            eng_tx     = data_in;
            data_ready = byte_due;
         end
         default:  eng_tx = FILL_BYTE;
      endcase
      eng_load = byte_due && ((state != ST_DATA) || data_valid);
      spi_cs   = (state == ST_IDLE) || (state == ST_DONE);
      busy     = (state != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt    <= '0;
         busy_cnt    <= '0;
         addr_q      <= '0;
         err_q       <= ERR_OK;
         write_done  <= 1'b0;
         write_error <= 1'b0;
      end else begin
         write_done  <= 1'b0;
         write_error <= 1'b0;
         if (state == ST_IDLE && start_write) begin
            addr_q   <= write_addr;
            err_q    <= ERR_OK;
            byte_cnt <= '0;
            busy_cnt <= '0;
         end
         if (eng_done) begin
            case (state)
               ST_CMD:
                  byte_cnt <= (byte_cnt == 10'(CMD_BYTES - 1)) ? 10'd0 : byte_cnt + 10'd1;
               ST_R1:
                  if (!eng_rx[7]) begin
                     byte_cnt <= '0;
                     if (eng_rx != 8'h00) err_q <= ERR_R1_NONZERO;
                  end else if (byte_cnt == 10'(R1_MAX_BYTES - 1)) begin
                     err_q <= ERR_R1_TIMEOUT;
                  end else begin
                     byte_cnt <= byte_cnt + 10'd1;
                  end
               ST_DATA:
                  byte_cnt <= (byte_cnt == 10'(BLOCK_BYTES - 1)) ? 10'd0 : byte_cnt + 10'd1;
               ST_CRC:
                  byte_cnt <= (byte_cnt == 10'(CRC_BYTES - 1)) ? 10'd0 : byte_cnt + 10'd1;
               ST_DRESP: begin
                  busy_cnt <= '0;
                  if (!dresp_ok) err_q <= ERR_DATA_REJECT;
               end
               ST_BUSYW:
                  if (eng_rx == 8'h00) begin
                     if (busy_last) err_q <= ERR_BUSY_TIMEOUT;
                     else           busy_cnt <= busy_cnt + BW'(1);
                  end
               ST_DONE: begin
                  write_done  <= 1'b1;
                  write_error <= (err_q != ERR_OK);
               end
               default: ;
            endcase
         end
      end
   end

   assign err_code = err_q;
endmodule

// File: tb/tb_sd_block_writer.sv
// Directed bench for sd_block_writer: a byte-indexed SD card model answers on MISO
// and logs MOSI; table vectors plus stall and reset-abort sequences.
module tb_sd_block_writer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start_write = 1'b0;
   logic [31:0] write_addr = '0;
   logic [7:0]  data_in;
   logic        data_valid = 1'b1;
   logic        data_ready, spi_cs, spi_mosi, spi_miso, spi_sclk;
   logic        busy, write_done, write_error;
   logic [2:0]  err_code;

   sd_block_writer #(.CLK_DIV(1), .BUSY_TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n), .start_write(start_write), .write_addr(write_addr),
      .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
      .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_sclk(spi_sclk),
      .busy(busy), .write_done(write_done), .write_error(write_error), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          r1_pos;
      logic [7:0]  r1_val;
      logic [7:0]  dresp;
      int          busy_n;
      logic [2:0]  exp_err;
      int          exp_hs;
   } vec_t;

   int n_chk = 0, n_pass = 0;
   int hs_cnt = 0, rdy_cycles = 0, done_cnt = 0, orphan_err = 0;
   int done_edges = 0, done_mosi_low = 0;
   int hs_base = 0;
   int bit_pos = 0;
   logic card_clr = 1'b0;
   int cfg_r1_idx = 7, cfg_dresp_idx = 524, cfg_busy_n = 0;
   logic [7:0] cfg_r1_val = 8'h00, cfg_dresp = 8'hE5;
   logic [7:0] mosi_log [0:1023];

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 7 + 3 + (i >>> 8));
   endfunction

   function automatic logic [7:0] resp_byte(input int idx, input int r1i, input logic [7:0] r1v,
                                            input int dri, input logic [7:0] drv, input int bn);
      if (idx == r1i) return r1v;
      if (idx == dri) return drv;
      if (idx > dri && idx <= dri + bn) return 8'h00;
      return 8'hFF;
   endfunction

   function automatic logic resp_bit(input int p, input int r1i, input logic [7:0] r1v,
                                     input int dri, input logic [7:0] drv, input int bn);
      logic [7:0] b;
      b = resp_byte(p >>> 3, r1i, r1v, dri, drv, bn);
      return b[3'(7 - (p & 7))];
   endfunction

   assign data_in  = pat(hs_cnt - hs_base);
   assign spi_miso = resp_bit(bit_pos, cfg_r1_idx, cfg_r1_val, cfg_dresp_idx, cfg_dresp, cfg_busy_n);

   // Card advances its output bit after each falling SCLK edge while selected.
   always @(negedge spi_sclk or posedge card_clr)
      if (card_clr)     bit_pos <= 0;
      else if (!spi_cs) bit_pos <= bit_pos + 1;

   always @(posedge spi_sclk)
      if (!spi_cs) begin
         if (bit_pos < 8 * 1024) mosi_log[bit_pos >>> 3][3'(7 - (bit_pos & 7))] <= spi_mosi;
      end else begin
         done_edges <= done_edges + 1;
         if (!spi_mosi) done_mosi_low <= done_mosi_low + 1;
      end

   always @(posedge clk) begin
      if (data_ready && data_valid) hs_cnt <= hs_cnt + 1;
      if (data_ready) rdy_cycles <= rdy_cycles + 1;
      if (write_done) done_cnt <= done_cnt + 1;
      if (write_error && !write_done) orphan_err <= orphan_err + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_case(input vec_t v, input int stall_at, input int reset_at);
      int b_hs, b_rdy, b_done, b_edges, b_low, b_orph, bad, r1i;
      bit got;
      r1i           = 6 + v.r1_pos;
      cfg_r1_idx    = r1i;
      cfg_r1_val    = v.r1_val;
      cfg_dresp_idx = r1i + 3 + 512 + 2;
      cfg_dresp     = v.dresp;
      cfg_busy_n    = v.busy_n;
      card_clr = 1'b1; #1; card_clr = 1'b0;
      hs_base = hs_cnt;
      b_hs = hs_cnt; b_rdy = rdy_cycles; b_done = done_cnt;
      b_edges = done_edges; b_low = done_mosi_low; b_orph = orphan_err;
      @(negedge clk); write_addr = v.addr; start_write = 1'b1;
      @(negedge clk); start_write = 1'b0; write_addr = ~v.addr;
      chk("accept_busy", busy, 1'b1);
      chk("accept_err_cleared", err_code, 3'd0);
      chk("accept_cs_low", spi_cs, 1'b0);
      if (stall_at >= 0) begin
         for (int i = 0; i < 20000 && (hs_cnt - hs_base) < stall_at; i++) @(negedge clk);
         chk("stall_reached", hs_cnt - hs_base, stall_at);
         data_valid = 1'b0;
         repeat (30) @(negedge clk);
         start_write = 1'b1;
         @(negedge clk); start_write = 1'b0;
         repeat (9) @(negedge clk);
         bad = 0;
         repeat (960) begin
            @(negedge clk);
            if (spi_sclk !== 1'b0 || spi_cs !== 1'b0 || data_ready !== 1'b1) bad++;
         end
         chk("stall_static_sclk_cs_ready", bad, 0);
         data_valid = 1'b1;
      end
      if (reset_at >= 0) begin
         for (int i = 0; i < 20000 && (hs_cnt - hs_base) < reset_at; i++) @(negedge clk);
         chk("abort_point_reached", hs_cnt - hs_base, reset_at);
         #2 reset_n = 1'b0;
         #1 chk("abort_cs_sclk_mosi_busy_ready", {spi_cs, spi_sclk, spi_mosi, busy, data_ready}, 5'b10100);
         repeat (3) @(negedge clk);
         reset_n = 1'b1;
         repeat (1500) @(negedge clk);
         chk("abort_no_write_done", done_cnt - b_done, 0);
         chk("abort_idle_err", {busy, err_code}, 4'b0000);
         return;
      end
      got = 1'b0;
      for (int i = 0; i < 15000; i++) begin
         @(negedge clk);
         if (write_done) begin got = 1'b1; break; end
      end
      chk("write_done_seen", got, 1'b1);
      if (!got) begin
         reset_n = 1'b0; #3 reset_n = 1'b1;
         return;
      end
      chk("err_code", err_code, v.exp_err);
      chk("write_error", write_error, (v.exp_err != 3'd0));
      chk("busy_low_at_done", busy, 1'b0);
      @(negedge clk);
      chk("write_done_one_cycle", write_done, 1'b0);
      chk("err_code_held", err_code, v.exp_err);
      chk("cmd_bytes", {mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4], mosi_log[5]},
          {8'h58, v.addr, 8'hFF});
      chk("handshakes", hs_cnt - b_hs, v.exp_hs);
      if (stall_at < 0) chk("ready_cycles", rdy_cycles - b_rdy, v.exp_hs);
      chk("done_pulses", done_cnt - b_done, 1);
      chk("orphan_error", orphan_err - b_orph, 0);
      chk("trailing_sclk_cs_high", done_edges - b_edges, 8);
      chk("trailing_mosi_high", done_mosi_low - b_low, 0);
      if (v.exp_hs == 512) begin
         chk("gap_token", {mosi_log[r1i + 1], mosi_log[r1i + 2]}, 16'hFFFE);
         bad = 0;
         for (int i = 0; i < 512; i++) if (mosi_log[r1i + 3 + i] !== pat(i)) bad++;
         chk("payload_order", bad, 0);
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{32'h0000_0258, 1, 8'h00, 8'hE5, 3,   3'd0, 512};
      vecs[1] = '{32'hDEAD_BEEF, 7, 8'h00, 8'hE5, 15,  3'd0, 512};
      vecs[2] = '{32'h1234_5678, 0, 8'h04, 8'hE5, 0,   3'd2, 0};
      vecs[3] = '{32'h0000_0001, 8, 8'h00, 8'hE5, 0,   3'd1, 0};
      vecs[4] = '{32'h0000_0002, 1, 8'h00, 8'hEB, 0,   3'd3, 512};
      vecs[5] = '{32'h0000_0003, 1, 8'h00, 8'hE5, 100, 3'd4, 512};

      #3 reset_n = 1'b0;
      #4 chk("reset_outputs",
             {spi_cs, spi_sclk, spi_mosi, busy, data_ready, write_done, write_error, err_code},
             10'b10_1000_0000);
      @(negedge clk); reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_after_reset", {spi_cs, spi_mosi, busy, data_ready}, 4'b1100);

      for (int i = 0; i < 6; i++) run_case(vecs[i], -1, -1);
      run_case(vecs[0], -1, 300);
      run_case(vecs[1], 100, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
